// File: rtl/prog_loader_if.sv
// Stream/instruction-memory bundle between a program source and prog_loader.
// master = stream source / observer side, slave = the loader.
interface prog_loader_if #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 24
);
  logic               start;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               im_we;
  logic [DATA_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Packs a byte stream into 24-bit instructions and writes them to im, holding the CPU meanwhile.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR   | accepting instruction count N
//   BYTE  | accepting instruction bytes, MSB first
//   WRITE | one-cycle im write of the assembled word
//   CHK   | accepting checksum byte (checksum build only)
//   DONE  | image loaded, CPU released
//   ERR   | checksum mismatch, CPU held (checksum build only)
module prog_loader #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 24
) (
  input logic          clk,
  input logic          rst_n,
  prog_loader_if.slave ld_if
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, BYTE, WRITE, CHK, DONE, ERR} state_t;
  localparam state_t END_ST = CHK;
`else
  typedef enum logic [2:0] {IDLE, HDR, BYTE, WRITE, DONE} state_t;
  localparam state_t END_ST = DONE;
`endif

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  n_q, n_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic               in_ready;
  logic               xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == HDR) || (state_q == BYTE) || (state_q == CHK);
`else
  assign in_ready = (state_q == HDR) || (state_q == BYTE);
`endif
  assign xfer = ld_if.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    word_d  = word_q;
    idx_d   = idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (ld_if.start) begin
          state_d = HDR;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      HDR: begin
        if (xfer) begin
          n_d     = ld_if.in_data;
          idx_d   = '0;
          state_d = (ld_if.in_data == '0) ? END_ST : BYTE;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = ld_if.in_data;
`endif
        end
      end
      BYTE: begin
        if (xfer) begin
          word_d = {word_q[INSTR_W-DATA_W-1:0], ld_if.in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ ld_if.in_data;
`endif
          if (idx_q == 2'd2) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        // Count stops at N, so N=255 never wraps back to address 0.
        addr_d  = addr_q + DATA_W'(1);
        state_d = ((addr_q + DATA_W'(1)) == n_q) ? END_ST : BYTE;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) state_d = (ld_if.in_data == csum_q) ? DONE : ERR;
      end
      ERR: begin
        if (ld_if.start) begin
          state_d = HDR;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
`endif
      DONE: begin
        if (ld_if.start) begin
          state_d = HDR;
          addr_d  = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_if.in_ready = in_ready;
  assign ld_if.im_we    = (state_q == WRITE);
  assign ld_if.im_addr  = addr_q;
  assign ld_if.im_wdata = word_q;
  assign ld_if.cpu_hold = (state_q != DONE);
  assign ld_if.done     = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign ld_if.error    = (state_q == ERR);
`else
  assign ld_if.error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads plus randomized programs
// compared against an expected write list built from the byte stream.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst_n;

  prog_loader_if #(.DATA_W(8), .INSTR_W(24)) ld_if ();

  prog_loader #(.DATA_W(8), .INSTR_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_if (ld_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_in_write = 0;
  logic [7:0]  wa_q[$];
  logic [23:0] wd_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ld_if.im_we) begin
      wa_q.push_back(ld_if.im_addr);
      wd_q.push_back(ld_if.im_wdata);
      if (ld_if.in_ready) rdy_in_write++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    ld_if.in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    ld_if.in_valid = 1'b1;
    ld_if.in_data  = b;
    t = 0;
    while (!ld_if.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("rdy_wait", 32'(t < 200), 32'd1);
    @(negedge clk);
    ld_if.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_if.start = 1'b1;
    @(negedge clk);
    ld_if.start = 1'b0;
    check_val("start_hold", 32'(ld_if.cpu_hold), 32'd1);
    check_val("start_done", 32'(ld_if.done), 32'd0);
    check_val("start_err", 32'(ld_if.error), 32'd0);
  endtask

  task automatic load_and_check(input string tag, input logic [7:0] n, input logic [7:0] data[$],
                                input int stall_lo, input int stall_hi, input bit corrupt,
                                output int fin_cycles);
    logic [7:0] x;
    bit exp_err;
    int t;
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send_byte(n, $urandom_range(stall_lo, stall_hi));
    x = n;
    foreach (data[i]) begin
      send_byte(data[i], $urandom_range(stall_lo, stall_hi));
      x ^= data[i];
    end
    exp_err = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_err = corrupt;
    send_byte(corrupt ? (x ^ 8'h5A) : x, $urandom_range(stall_lo, stall_hi));
`endif
    t = 0;
    while (!(ld_if.done || ld_if.error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    fin_cycles = t;
    check_val({tag, "_fin"}, 32'(t < 50), 32'd1);
    check_val({tag, "_done"}, 32'(ld_if.done), 32'(!exp_err));
    check_val({tag, "_err"}, 32'(ld_if.error), 32'(exp_err));
    check_val({tag, "_hold"}, 32'(ld_if.cpu_hold), 32'(exp_err));
    check_val({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
    for (int k = 0; k < int'(n) && k < wa_q.size(); k++) begin
      check_val({tag, "_addr"}, 32'(wa_q[k]), 32'(k));
      check_val({tag, "_data"}, 32'(wd_q[k]), {8'h00, data[3*k], data[3*k+1], data[3*k+2]});
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_rdy"}, 32'(ld_if.in_ready), 32'd0);
    check_val({tag, "_we"}, 32'(ld_if.im_we), 32'd0);
    check_val({tag, "_addr"}, 32'(ld_if.im_addr), 32'd0);
    check_val({tag, "_wdata"}, 32'(ld_if.im_wdata), 32'd0);
    check_val({tag, "_hold"}, 32'(ld_if.cpu_hold), 32'd1);
    check_val({tag, "_done"}, 32'(ld_if.done), 32'd0);
    check_val({tag, "_err"}, 32'(ld_if.error), 32'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] n;
    int fc;
    ld_if.start    = 1'b0;
    ld_if.in_valid = 1'b0;
    ld_if.in_data  = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    d = '{8'h04, 8'h0C, 8'h21, 8'h08, 8'h00, 8'h43};
    load_and_check("t1", 8'd2, d, 0, 0, 1'b0, fc);
    if (wd_q.size() == 2) begin
      check_val("t1_w0", 32'(wd_q[0]), 32'h040C21);
      check_val("t1_w1", 32'(wd_q[1]), 32'h080043);
    end

    load_and_check("t2", 8'd2, d, 5, 5, 1'b0, fc);

    d.delete();
    load_and_check("t3", 8'd0, d, 0, 0, 1'b0, fc);
    check_val("t3_lat", 32'(fc <= 2), 32'd1);

    // Reset after byte1 of word 1.
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0);
    #2 rst_n = 1'b0;
    #1 check_reset("t4");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = '{8'h9A, 8'hBC, 8'hDE};
    load_and_check("t4r", 8'd1, d, 0, 1, 1'b0, fc);

`ifdef PROG_LOADER_CHECKSUM_EN
    d = '{8'hAA, 8'hBB, 8'hCC};
    load_and_check("t5bad", 8'd1, d, 0, 0, 1'b1, fc);
    load_and_check("t5ok", 8'd1, d, 0, 0, 1'b0, fc);
`endif

    d = '{8'hFF, 8'hFF, 8'hFF};
    load_and_check("t6", 8'd1, d, 0, 0, 1'b0, fc);
    if (wd_q.size() == 1) check_val("t6_w0", 32'(wd_q[0]), 32'hFFFFFF);

    for (int r = 0; r < 20; r++) begin
      n = 8'($urandom_range(1, 12));
      d.delete();
      for (int i = 0; i < 3 * int'(n); i++) d.push_back(8'($urandom_range(0, 255)));
      load_and_check("rnd", n, d, 0, 3, 1'($urandom_range(0, 1)), fc);
    end

    d.delete();
    for (int i = 0; i < 3 * 255; i++) d.push_back(8'($urandom_range(0, 255)));
    load_and_check("n255", 8'd255, d, 0, 0, 1'b0, fc);
    if (wa_q.size() == 255) check_val("n255_last", 32'(wa_q[254]), 32'd254);

    check_val("rdy_in_write", 32'(rdy_in_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
